lock_controller: RTL

// - Door-lock sequencer: collects 4 keypad digits, compares them against a fixed passcode, drives the bolt.
// - Produces the 3-bit state code consumed by the 7-segment state decoder; it is the source of that code.
// - Sits between the keypad scanner (digit pulses) and the display/bolt outputs.

---
 rtl/lock_pkg.sv | 45 ++++
 rtl/lock_timer.sv | 32 +++
 rtl/lock_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the door-lock sequencer and the 7-segment state decoder.
// The state codes live here so the display side and the controller never drift apart.
package lock_pkg;

    // State codes presented on o_state; 3'b110 and 3'b111 are never produced.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_GOT1 = 3'b001,
        ST_GOT2 = 3'b010,
        ST_GOT3 = 3'b011,
        ST_OPEN = 3'b100,
        ST_FAIL = 3'b101
    } lock_state_e;

    // Any key code at or above this value is a CLEAR key.
    localparam logic [3:0] KEY_CLEAR_MIN = 4'hA;

    // True when the key code is one of the CLEAR keys.
    function automatic logic is_clear_key(input logic [3:0] key);
        return (key >= KEY_CLEAR_MIN);
    endfunction

    // Largest of four timing parameters, used to size the shared timer.
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        if (d > m) begin
            m = d;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by every timed state of the lock controller.
// A load sets the count; the counter then steps down to zero and rests there.
module lock_timer
    import lock_pkg::*;
#(
    parameter int TIMER_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_value,
    output logic               o_expired
);

    logic [TIMER_W-1:0] count_r;

    // Count register: load wins, otherwise decrement until zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (i_load) begin
            count_r <= i_value;
        end else if (count_r != {TIMER_W{1'b0}}) begin
            count_r <= count_r - {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign o_expired = (count_r == {TIMER_W{1'b0}});

endmodule

// File: rtl/lock_controller.sv
// Door-lock sequencer: gathers four keypad digits, judges them against the
// passcode, releases the bolt on a match and enforces a lockout after repeated
// failures. o_state feeds the 7-segment state decoder.
module lock_controller
    import lock_pkg::*;
#(
    parameter logic [15:0] PASSCODE       = 16'h1234,
    parameter int          OPEN_CYCLES    = 32'd50_000_000,
    parameter int          FAIL_CYCLES    = 32'd25_000_000,
    parameter int          ENTRY_TIMEOUT  = 32'd100_000_000,
    parameter int          MAX_FAILS      = 32'd3,
    parameter int          LOCKOUT_CYCLES = 32'd250_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_valid,
    input  logic [3:0] i_key,
    input  logic       i_lock,
    output logic [2:0] o_state,
    output logic       o_unlock,
    output logic       o_alarm
);

    localparam int TIMER_MAX = max_of4(OPEN_CYCLES, FAIL_CYCLES, ENTRY_TIMEOUT, LOCKOUT_CYCLES);
    localparam int TIMER_W   = $clog2(TIMER_MAX) + 1;

    // Load values are one less than the visible duration: the count reaching
    // zero marks the last cycle spent in the state.
    localparam logic [TIMER_W-1:0] LOAD_OPEN    = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOAD_FAIL    = TIMER_W'(FAIL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOAD_ENTRY   = TIMER_W'(ENTRY_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] LOAD_LOCKOUT = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]         MAX_FAILS_C  = 3'(MAX_FAILS);

    lock_state_e        state_r;
    lock_state_e        state_nxt_s;
    logic [15:0]        digits_r;
    logic [15:0]        digits_nxt_s;
    logic [2:0]         fail_cnt_r;
    logic [2:0]         fail_cnt_nxt_s;
    logic [2:0]         fail_inc_s;
    logic               unlock_r;
    logic               unlock_nxt_s;
    logic               alarm_r;
    logic               alarm_nxt_s;
    logic               load_s;
    logic [TIMER_W-1:0] load_val_s;
    logic               expired_s;
    logic               key_digit_s;
    logic               key_clear_s;
    logic [15:0]        entry_s;
    logic               match_s;

    lock_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (load_s),
        .i_value   (load_val_s),
        .o_expired (expired_s)
    );

    assign key_digit_s = i_key_valid & ~is_clear_key(i_key);
    assign key_clear_s = i_key_valid &  is_clear_key(i_key);
    assign entry_s     = {digits_r[11:0], i_key};
    // Only three digits are ever buffered before the verdict, so a non-zero
    // top nibble means the buffer is corrupt and must not open the bolt.
    assign match_s     = (entry_s == PASSCODE) && (digits_r[15:12] == 4'h0);
    assign fail_inc_s  = (fail_cnt_r < MAX_FAILS_C) ? (fail_cnt_r + 3'd1) : fail_cnt_r;

    // Next-state, buffer, fail-count and timer-load decisions; i_lock beats
    // CLEAR, CLEAR beats a digit, a digit beats timer expiry.
    always_comb begin
        state_nxt_s    = state_r;
        digits_nxt_s   = digits_r;
        fail_cnt_nxt_s = fail_cnt_r;
        alarm_nxt_s    = alarm_r;
        load_s         = 1'b0;
        load_val_s     = LOAD_ENTRY;
        case (state_r)
            ST_IDLE: begin
                if (i_lock || key_clear_s) begin
                    state_nxt_s  = ST_IDLE;
                    digits_nxt_s = 16'h0000;
                end else if (key_digit_s) begin
                    state_nxt_s  = ST_GOT1;
                    digits_nxt_s = entry_s;
                    load_s       = 1'b1;
                    load_val_s   = LOAD_ENTRY;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_GOT1, ST_GOT2: begin
                if (i_lock || key_clear_s) begin
                    state_nxt_s  = ST_IDLE;
                    digits_nxt_s = 16'h0000;
                end else if (key_digit_s) begin
                    state_nxt_s  = (state_r == ST_GOT1) ? ST_GOT2 : ST_GOT3;
                    digits_nxt_s = entry_s;
                    load_s       = 1'b1;
                    load_val_s   = LOAD_ENTRY;
                end else if (expired_s) begin
                    state_nxt_s  = ST_IDLE;
                    digits_nxt_s = 16'h0000;
                end else begin
                    state_nxt_s  = state_r;
                end
            end
            ST_GOT3: begin
                if (i_lock || key_clear_s) begin
                    state_nxt_s  = ST_IDLE;
                    digits_nxt_s = 16'h0000;
                end else if (key_digit_s) begin
                    digits_nxt_s = entry_s;
                    load_s       = 1'b1;
                    if (match_s) begin
                        state_nxt_s    = ST_OPEN;
                        fail_cnt_nxt_s = 3'd0;
                        alarm_nxt_s    = 1'b0;
                        load_val_s     = LOAD_OPEN;
                    end else begin
                        state_nxt_s    = ST_FAIL;
                        fail_cnt_nxt_s = fail_inc_s;
                        if (fail_inc_s >= MAX_FAILS_C) begin
                            alarm_nxt_s = 1'b1;
                            load_val_s  = LOAD_LOCKOUT;
                        end else begin
                            alarm_nxt_s = 1'b0;
                            load_val_s  = LOAD_FAIL;
                        end
                    end
                end else if (expired_s) begin
                    state_nxt_s  = ST_IDLE;
                    digits_nxt_s = 16'h0000;
                end else begin
                    state_nxt_s  = ST_GOT3;
                end
            end
            ST_OPEN: begin
                if (i_lock || expired_s) begin
                    state_nxt_s  = ST_IDLE;
                    digits_nxt_s = 16'h0000;
                end else begin
                    state_nxt_s  = ST_OPEN;
                end
            end
            ST_FAIL: begin
                if (expired_s) begin
                    state_nxt_s  = ST_IDLE;
                    digits_nxt_s = 16'h0000;
                    alarm_nxt_s  = 1'b0;
                    if (alarm_r) begin
                        fail_cnt_nxt_s = 3'd0;
                    end else begin
                        fail_cnt_nxt_s = fail_cnt_r;
                    end
                end else begin
                    state_nxt_s  = ST_FAIL;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                digits_nxt_s   = 16'h0000;
                fail_cnt_nxt_s = 3'd0;
                alarm_nxt_s    = 1'b0;
            end
        endcase
        unlock_nxt_s = (state_nxt_s == ST_OPEN);
    end

    // State, buffer, fail count and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            digits_r   <= 16'h0000;
            fail_cnt_r <= 3'd0;
            unlock_r   <= 1'b0;
            alarm_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            digits_r   <= digits_nxt_s;
            fail_cnt_r <= fail_cnt_nxt_s;
            unlock_r   <= unlock_nxt_s;
            alarm_r    <= alarm_nxt_s;
        end
    end

    assign o_state  = state_r;
    assign o_unlock = unlock_r;
    assign o_alarm  = alarm_r;

endmodule
